llr_frame_loader: RTL and testbench
===================================

# llr_frame_loader

Upstream feeder for the `bcjr_max_product` SISO decoder. It accepts a serial stream of channel LLR words and depunctures them, inserting `+0.0` at punctured parity positions. It assembles one frame into the parallel `LLRVector[BITS_PER_SYMBOL][SYMBOLS]` array, issues a single-cycle start pulse to the decoder, and holds the array stable until the decoder signals completion.

## Interface
- `BITS`, 32, LLR word width; IEEE float bit pattern, matching the decoder `BITS`.
- `BITS_PER_SYMBOL`, 2, rows of `LLRVector`; row 0 is systematic, rows ≥1 are parity.
- `SYMBOLS`, 5, columns of `LLRVector` (trellis steps per frame).
- `PUNCTURE`, 0, when 1, rows ≥1 of odd-index symbols are punctured (absent from the stream).

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  loader can accept a word.
- `s_data`  in  BITS  LLR word.
- `s_last`  in  1  marks the final word of a frame.
- `dec_in_valid`  out  1  one-cycle start pulse to the decoder's `in_valid`.
- `LLRVector`  out  BITS × [BITS_PER_SYMBOL][SYMBOLS]  frame to the decoder.
- `dec_done`  in  1  decoder `out_valid`.
- `busy`  out  1  high in ISSUE and WAIT.
- `frame_err`  out  1  one-cycle pulse on a frame-length mismatch.

## Operation
- Stream order is symbol-major: for j = 0..SYMBOLS-1, then i = 0..BITS_PER_SYMBOL-1. Punctured (i, j) positions are skipped in the stream.
- Expected beats N:
  - `PUNCTURE`=0: N = BITS_PER_SYMBOL·SYMBOLS.
  - `PUNCTURE`=1: subtract (BITS_PER_SYMBOL−1)·floor(SYMBOLS/2).
  - Defaults give N = 10 unpunctured and N = 8 punctured.
- Write pointer (i, j) advances over non-punctured positions only. Punctured cells hold 0 (`+0.0`).
- FSM states:
  - LOAD: `s_ready`=1. Each accepted beat (`s_valid && s_ready`) writes `s_data` to `LLRVector[i][j]`. On the N-th beat, or on any beat with `s_last`=1, go to ISSUE.
  - ISSUE: `dec_in_valid`=1 for exactly this cycle; `s_ready`=0. Unconditionally go to WAIT.
  - WAIT: `s_ready`=0; `LLRVector` is frozen. When `dec_done`=1, clear the whole array to 0, reset the pointer, and go to LOAD.
- Length checks:
  - `s_last` on beat k < N: remaining positions stay 0; `frame_err` pulses; the frame is still issued.
  - N-th beat without `s_last`: `frame_err` pulses; the frame is still issued.
  - `s_last` on the N-th beat: no error.
- `dec_done` is ignored in LOAD and ISSUE.
- `s_data` is not interpreted arithmetically. It is stored bit-exact.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - Outputs: `s_ready`=0, `dec_in_valid`=0, `busy`=0, `frame_err`=0, all `LLRVector` cells 0.
  - FSM state becomes LOAD; pointer goes to (0,0).
  - `s_ready`=1 from the first cycle after reset is released.
- Reset asserted mid-frame or in WAIT aborts the frame and clears the buffer. No `dec_in_valid` is emitted for the aborted frame.
- Final beat accepted at edge t:
  - `dec_in_valid` and `busy` are high in cycle t+1.
  - `frame_err`, if any, is also high in cycle t+1.
  - `LLRVector` holds the complete frame from cycle t+1.
- `dec_done` sampled high at edge w: the buffer clears at w, and `s_ready`=1 in cycle w+1.
- Throughput: one word per cycle in LOAD; no backpressure gaps inside a frame.
- `s_valid` low stalls the pointer with no state change.

## Test plan
- **Unpunctured frame.** Stream 10 words with `s_last` on the 10th:
  - `[0]={2,-2,-2,2,-2}`, `[1]={2,2,-2,2,2}`, as `0x40000000` / `0xC0000000` in symbol-major order.
  - Required response: the array matches exactly; one `dec_in_valid` pulse the cycle after beat 10; `frame_err`=0.
- **Punctured frame** (`PUNCTURE`=1). Stream 8 words:
  - Required response: `LLRVector[1][1]` and `LLRVector[1][3]` = `0x00000000`; all other cells in stream order; pulse after beat 8.
- **Hold and reload.** Keep `dec_done` low for 20 cycles with `s_valid`=1:
  - Required response: `s_ready`=0 and the array unchanged throughout.
  - Then pulse `dec_done`: the array becomes all 0 and `s_ready`=1 on the next cycle.
- **Early `s_last` on beat 4.**
  - Required response: cells from beat 5 onward are 0; `frame_err` and `dec_in_valid` pulse together.
  - Also check: a 10th beat sent without `s_last` gives `frame_err`=1.
- **Mid-frame reset.** Assert `rst_n`=0 for 1 cycle after beat 6:
  - Required response: no `dec_in_valid`; array all 0; the next frame loads from (0,0) correctly.
- **Back-to-back frames** with `dec_done` arriving 3 cycles after `dec_in_valid`:
  - Required response: the second frame starts loading the cycle after `dec_done`, and both frames are delivered intact.

Source files
------------

// File: rtl/llr_frame_loader.sv
// llr_frame_loader
//   Collects a serial stream of channel LLR words, depunctures it into the
//   LLRVector[BITS_PER_SYMBOL][SYMBOLS] array, fires a one-cycle start pulse
//   to the SISO decoder and holds the array until the decoder reports done.
//
// Ports
//   clk          : sole clock, rising edge
//   rst_n        : synchronous active-low reset
//   s_valid      : stream word valid
//   s_ready      : loader can accept a word (LOAD state only)
//   s_data       : LLR word, stored bit-exact
//   s_last       : final word of a frame
//   dec_in_valid : one-cycle start pulse to the decoder
//   LLRVector    : assembled frame, [row][column] of BITS-wide words
//   dec_done     : decoder out_valid; releases the buffer while waiting
//   busy         : high while the frame is issued / owned by the decoder
//   frame_err    : one-cycle pulse when the frame length was wrong
module llr_frame_loader #(
    parameter int unsigned BITS            = 32,
    parameter int unsigned BITS_PER_SYMBOL = 2,
    parameter int unsigned SYMBOLS         = 5,
    parameter int unsigned PUNCTURE        = 0
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                s_valid,
    output logic                                                s_ready,
    input  logic [BITS-1:0]                                     s_data,
    input  logic                                                s_last,
    output logic                                                dec_in_valid,
    output logic [BITS_PER_SYMBOL-1:0][SYMBOLS-1:0][BITS-1:0]   LLRVector,
    input  logic                                                dec_done,
    output logic                                                busy,
    output logic                                                frame_err
);

    // Beats per frame: odd columns carry only the systematic row when punctured.
    localparam int unsigned Beats = BITS_PER_SYMBOL * SYMBOLS -
        ((PUNCTURE != 0) ? (BITS_PER_SYMBOL - 1) * (SYMBOLS / 2) : 0);
    localparam int unsigned RowW  = (BITS_PER_SYMBOL > 1) ? $clog2(BITS_PER_SYMBOL) : 1;
    localparam int unsigned ColW  = (SYMBOLS > 1) ? $clog2(SYMBOLS + 1) : 1;
    localparam int unsigned CntW  = $clog2(Beats + 1);

    typedef enum logic [1:0] {StLoad, StIssue, StWait} state_e;

    state_e                                             state_q;
    logic [RowW-1:0]                                    row_q, row_d;
    logic [ColW-1:0]                                    col_q, col_d;
    logic [CntW-1:0]                                    cnt_q;
    logic [BITS_PER_SYMBOL-1:0][SYMBOLS-1:0][BITS-1:0]  buf_q;
    logic                                               s_ready_q;
    logic                                               dec_in_valid_q;
    logic                                               busy_q;
    logic                                               frame_err_q;

    logic accept;
    logic nth_beat;

    assign accept   = s_valid && s_ready_q && (state_q == StLoad);
    assign nth_beat = (cnt_q == CntW'(Beats - 1));

    // Next write position, skipping the parity rows of odd columns when punctured.
    always_comb begin
        row_d = row_q + RowW'(1);
        col_d = col_q;
        if ((row_q == RowW'(BITS_PER_SYMBOL - 1)) || ((PUNCTURE != 0) && col_q[0])) begin
            row_d = '0;
            col_d = col_q + ColW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StLoad;
            row_q          <= '0;
            col_q          <= '0;
            cnt_q          <= '0;
            buf_q          <= '0;
            s_ready_q      <= 1'b0;
            dec_in_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        buf_q[row_q][col_q] <= s_data;
                        row_q               <= row_d;
                        col_q               <= col_d;
                        cnt_q               <= cnt_q + CntW'(1);
                        if (nth_beat || s_last) begin
                            state_q        <= StIssue;
                            s_ready_q      <= 1'b0;
                            dec_in_valid_q <= 1'b1;
                            busy_q         <= 1'b1;
                            // Error when exactly one of "N-th beat" / "s_last" holds.
                            frame_err_q    <= nth_beat ^ s_last;
                        end
                    end
                end
                StIssue: begin
                    dec_in_valid_q <= 1'b0;
                    frame_err_q    <= 1'b0;
                    state_q        <= StWait;
                end
                StWait: begin
                    if (dec_done) begin
                        state_q   <= StLoad;
                        buf_q     <= '0;
                        row_q     <= '0;
                        col_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b0;
                        s_ready_q <= 1'b1;
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign s_ready      = s_ready_q;
    assign dec_in_valid = dec_in_valid_q;
    assign busy         = busy_q;
    assign frame_err    = frame_err_q;
    assign LLRVector    = buf_q;

endmodule

// File: tb/tb_llr_frame_loader.sv
// Bench for llr_frame_loader: one unpunctured (dut0) and one punctured (dut1)
// instance, driven from a vector table plus random frames and hand sequences.
module tb_llr_frame_loader;

    typedef logic [1:0][4:0][31:0] arr_t;
    typedef struct {
        int d;
        int k;
        bit last;
        int hold;
        bit fixed;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid[2];
    logic        s_ready[2];
    logic [31:0] s_data[2];
    logic        s_last[2];
    logic        dec_in_valid[2];
    arr_t        llr[2];
    logic        dec_done[2];
    logic        busy[2];
    logic        frame_err[2];

    int          tests = 0;
    int          fails = 0;
    int          pulses[2];
    logic [31:0] words[10];
    arr_t        exp_arr;
    bit          exp_err;

    always #5 clk = ~clk;

    llr_frame_loader #(.BITS(32), .BITS_PER_SYMBOL(2), .SYMBOLS(5), .PUNCTURE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_data(s_data[0]), .s_last(s_last[0]), .dec_in_valid(dec_in_valid[0]),
        .LLRVector(llr[0]), .dec_done(dec_done[0]), .busy(busy[0]), .frame_err(frame_err[0])
    );

    llr_frame_loader #(.BITS(32), .BITS_PER_SYMBOL(2), .SYMBOLS(5), .PUNCTURE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_data(s_data[1]), .s_last(s_last[1]), .dec_in_valid(dec_in_valid[1]),
        .LLRVector(llr[1]), .dec_done(dec_done[1]), .busy(busy[1]), .frame_err(frame_err[1])
    );

    // Counts cycles in which each start pulse was high.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) if (dec_in_valid[d] === 1'b1) pulses[d]++;
    end

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: list the non-punctured cells in stream order, fill the first k.
    task automatic build_model(input int d, input int k, input bit last, input bit fixed);
        int pi[$];
        int pj[$];
        bit neg;
        for (int j = 0; j < 5; j++)
            for (int i = 0; i < 2; i++)
                if (!(d == 1 && (j % 2) == 1 && i >= 1)) begin
                    pi.push_back(i);
                    pj.push_back(j);
                end
        exp_arr = '0;
        for (int b = 0; b < k; b++) begin
            // Fixed pattern: row0 = {2,-2,-2,2,-2}, row1 = {2,2,-2,2,2}
            neg = (pi[b] == 0) ? (pj[b] == 1 || pj[b] == 2 || pj[b] == 4) : (pj[b] == 2);
            if (fixed) words[b] = neg ? 32'hC000_0000 : 32'h4000_0000;
            else       words[b] = $urandom;
            exp_arr[pi[b]][pj[b]] = words[b];
        end
        exp_err = last ? (k < pi.size()) : (k == pi.size());
    endtask

    task automatic stream(input int d, input int k, input bit last, input int gap_pct,
                          input bit first_now, output int cycles, output bit ok);
        int b = 0;
        bit acc;
        cycles = 0;
        ok     = 1'b1;
        while (b < k) begin
            if (cycles >= 300) begin
                ok = 1'b0;
                break;
            end
            if (!(first_now && cycles == 0)) @(negedge clk);
            dec_done[d] = 1'($urandom_range(0, 1));
            if (int'($urandom_range(0, 99)) < gap_pct) begin
                s_valid[d] = 1'b0;
                s_data[d]  = $urandom;
                s_last[d]  = 1'($urandom_range(0, 1));
            end else begin
                s_valid[d] = 1'b1;
                s_data[d]  = words[b];
                s_last[d]  = last && (b == k - 1);
            end
            acc = s_valid[d] && s_ready[d];
            @(posedge clk);
            cycles++;
            if (acc) b++;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL stream_timeout: got %0d beats, expected %0d", b, k);
        end
    endtask

    // Called just after the final-beat edge t; returns at the negedge of cycle w+1.
    task automatic finish_frame(input int d, input int hold, input string tag);
        int p0 = pulses[d];
        @(negedge clk);
        chk({tag, "_dvalid"}, 320'(dec_in_valid[d]), 320'(1));
        chk({tag, "_busy"}, 320'(busy[d]), 320'(1));
        chk({tag, "_ferr"}, 320'(frame_err[d]), 320'(exp_err));
        chk({tag, "_ready_issue"}, 320'(s_ready[d]), 320'(0));
        chk({tag, "_array"}, llr[d], exp_arr);
        s_valid[d]  = 1'b1;
        s_data[d]   = $urandom;
        s_last[d]   = 1'($urandom_range(0, 1));
        dec_done[d] = 1'b1;  // must be ignored during ISSUE
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            chk({tag, "_ready_wait"}, 320'(s_ready[d]), 320'(0));
            chk({tag, "_hold"}, {llr[d], dec_in_valid[d], frame_err[d], busy[d]},
                {exp_arr, 1'b0, 1'b0, 1'b1});
            s_data[d]   = $urandom;
            dec_done[d] = (c == hold - 1);
        end
        @(negedge clk);
        s_valid[d]  = 1'b0;
        dec_done[d] = 1'b0;
        s_last[d]   = 1'b0;
        chk({tag, "_cleared"}, llr[d], '0);
        chk({tag, "_ready_after"}, 320'(s_ready[d]), 320'(1));
        chk({tag, "_idle"}, 320'(busy[d]), 320'(0));
        chk({tag, "_one_pulse"}, 320'(pulses[d]), 320'(p0 + 1));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        vec_t v;
        int   cyc;
        bit   ok;
        int   p0;

        vecs.push_back('{d: 0, k: 10, last: 1, hold: 21, fixed: 1});
        vecs.push_back('{d: 1, k: 8,  last: 1, hold: 2,  fixed: 1});
        vecs.push_back('{d: 0, k: 4,  last: 1, hold: 1,  fixed: 0});
        vecs.push_back('{d: 0, k: 10, last: 0, hold: 1,  fixed: 0});
        vecs.push_back('{d: 1, k: 8,  last: 0, hold: 3,  fixed: 0});
        vecs.push_back('{d: 1, k: 3,  last: 1, hold: 1,  fixed: 0});
        vecs.push_back('{d: 0, k: 1,  last: 1, hold: 2,  fixed: 0});
        vecs.push_back('{d: 0, k: 10, last: 1, hold: 5,  fixed: 0});
        for (int n = 0; n < 10; n++) begin
            v.d     = int'($urandom_range(0, 1));
            v.last  = 1'($urandom_range(0, 1));
            v.k     = v.last ? int'($urandom_range(1, (v.d == 1) ? 8 : 10)) : ((v.d == 1) ? 8 : 10);
            v.hold  = int'($urandom_range(1, 6));
            v.fixed = 1'b0;
            vecs.push_back(v);
        end

        pulses[0] = 0;
        pulses[1] = 0;
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            s_valid[d]  = 1'b0;
            s_data[d]   = '0;
            s_last[d]   = 1'b0;
            dec_done[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_outs%0d", d),
                {llr[d], s_ready[d], dec_in_valid[d], busy[d], frame_err[d]}, '0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_ready0", 320'(s_ready[0]), 320'(1));
        chk("release_ready1", 320'(s_ready[1]), 320'(1));

        foreach (vecs[n]) begin
            v = vecs[n];
            build_model(v.d, v.k, v.last, v.fixed);
            stream(v.d, v.k, v.last, 25, 1'b0, cyc, ok);
            if (ok) finish_frame(v.d, v.hold, $sformatf("v%0d", n));
        end

        // Reset after beat 6 aborts the frame without a start pulse.
        build_model(0, 6, 1'b0, 1'b0);
        p0 = pulses[0];
        stream(0, 6, 1'b0, 0, 1'b0, cyc, ok);
        @(negedge clk);
        rst_n      = 1'b0;
        s_valid[0] = 1'b0;
        @(negedge clk);
        chk("midrst_array", llr[0], '0);
        chk("midrst_outs", {s_ready[0], dec_in_valid[0], busy[0], frame_err[0]}, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_ready", 320'(s_ready[0]), 320'(1));
        chk("midrst_no_pulse", 320'(pulses[0]), 320'(p0));
        build_model(0, 10, 1'b1, 1'b0);
        stream(0, 10, 1'b1, 20, 1'b0, cyc, ok);
        if (ok) finish_frame(0, 2, "midrst_next");

        // Back-to-back frames: decoder done 3 cycles after start, next frame gap-free.
        build_model(0, 10, 1'b1, 1'b0);
        stream(0, 10, 1'b1, 0, 1'b0, cyc, ok);
        if (ok) finish_frame(0, 3, "b2b_a");
        build_model(0, 10, 1'b1, 1'b0);
        stream(0, 10, 1'b1, 0, 1'b1, cyc, ok);
        chk("b2b_load_cycles", 320'(cyc), 320'(10));
        if (ok) finish_frame(0, 3, "b2b_b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
